// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
//   Two-road intersection controller (NS / EW) with all-red clearance,
//   latched pedestrian walk requests and a night flashing-yellow mode.
//   All timing is counted in ticks of the upstream prescaler enable.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   tick                 one-clk-wide timing enable
//   ped_req_ns/ew        button pulses requesting a walk parallel to NS/EW
//   night_mode           level request for flashing-yellow operation
//   ns_light, ew_light   {green, yellow, red}, registered
//   walk_ns, walk_ew     pedestrian walk signals, registered
//   remaining            ticks left in the current state, registered
//   state_out            current state code (debug)
module traffic_intersection_ctrl #(
  parameter int TIME_W   = 6,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              ped_req_ns,
  input  logic              ped_req_ew,
  input  logic              night_mode,
  output logic [2:0]        ns_light,
  output logic [2:0]        ew_light,
  output logic              walk_ns,
  output logic              walk_ew,
  output logic [TIME_W-1:0] remaining,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [TIME_W-1:0] GREEN_D  = TIME_W'(GREEN_T);
  localparam logic [TIME_W-1:0] YELLOW_D = TIME_W'(YELLOW_T);
  localparam logic [TIME_W-1:0] ALLRED_D = TIME_W'(ALLRED_T);
  localparam logic [TIME_W-1:0] PED_D    = TIME_W'(PED_T);
  localparam logic [TIME_W-1:0] ONE      = TIME_W'(1);

  state_t            state, state_d;
  logic [TIME_W-1:0] rem_d;
  logic [TIME_W-1:0] walk_cnt, walk_cnt_d;
  logic              walk_ns_d, walk_ew_d;
  logic              pend_ns, pend_ew, pend_ns_d, pend_ew_d;
  logic              phase, phase_d;
  logic [2:0]        ns_d, ew_d;
  logic              exit_edge;

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NS_GREEN;
      remaining <= GREEN_D;
      ns_light  <= 3'b100;
      ew_light  <= 3'b001;
      walk_ns   <= 1'b0;
      walk_ew   <= 1'b0;
      walk_cnt  <= '0;
      pend_ns   <= 1'b0;
      pend_ew   <= 1'b0;
      phase     <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= rem_d;
      ns_light  <= ns_d;
      ew_light  <= ew_d;
      walk_ns   <= walk_ns_d;
      walk_ew   <= walk_ew_d;
      walk_cnt  <= walk_cnt_d;
      pend_ns   <= pend_ns_d;
      pend_ew   <= pend_ew_d;
      phase     <= phase_d;
    end
  end

  always_comb begin
    state_d    = state;
    rem_d      = remaining;
    phase_d    = phase;
    walk_cnt_d = walk_cnt;
    walk_ns_d  = walk_ns;
    walk_ew_d  = walk_ew;
    // Requests latch on any clock, including the grant edge itself.
    pend_ns_d  = pend_ns | ped_req_ns;
    pend_ew_d  = pend_ew | ped_req_ew;
    ns_d       = 3'b001;
    ew_d       = 3'b001;
    exit_edge  = tick && (remaining == ONE);

    // Plain countdown; the transition cases below overwrite it on exit.
    if (tick && state != FLASH) begin
      rem_d = remaining - ONE;
    end

    case (state)
      NS_GREEN:  if (exit_edge) begin state_d = NS_YELLOW; rem_d = YELLOW_D; end
      NS_YELLOW: if (exit_edge) begin state_d = ALLRED_A;  rem_d = ALLRED_D; end
      ALLRED_A: begin
        if (exit_edge) begin
          if (night_mode) begin
            state_d = FLASH;    rem_d = '0; phase_d = 1'b1;
          end else begin
            state_d = EW_GREEN; rem_d = GREEN_D;
          end
        end
      end
      EW_GREEN:  if (exit_edge) begin state_d = EW_YELLOW; rem_d = YELLOW_D; end
      EW_YELLOW: if (exit_edge) begin state_d = ALLRED_B;  rem_d = ALLRED_D; end
      ALLRED_B: begin
        if (exit_edge) begin
          if (night_mode) begin
            state_d = FLASH;    rem_d = '0; phase_d = 1'b1;
          end else begin
            state_d = NS_GREEN; rem_d = GREEN_D;
          end
        end
      end
      FLASH: begin
        if (tick) begin
          if (!night_mode) begin
            state_d = ALLRED_B; rem_d = ALLRED_D;
          end else begin
            phase_d = ~phase;
          end
        end
      end
      default: begin
        state_d = ALLRED_B;
        rem_d   = ALLRED_D;
      end
    endcase

    // Any state change drops walk; entering a green may grant a new one.
    if (state_d != state) begin
      walk_ns_d = 1'b0;
      walk_ew_d = 1'b0;
      if (state_d == NS_GREEN && pend_ns_d) begin
        walk_ns_d  = 1'b1;
        pend_ns_d  = 1'b0;
        walk_cnt_d = PED_D;
      end
      if (state_d == EW_GREEN && pend_ew_d) begin
        walk_ew_d  = 1'b1;
        pend_ew_d  = 1'b0;
        walk_cnt_d = PED_D;
      end
    end else if (tick && (walk_ns || walk_ew)) begin
      walk_cnt_d = walk_cnt - ONE;
      if (walk_cnt == ONE) begin
        walk_ns_d = 1'b0;
        walk_ew_d = 1'b0;
      end
    end

    // Lights follow the state being entered so they stay registered.
    case (state_d)
      NS_GREEN:  begin ns_d = 3'b100; ew_d = 3'b001; end
      NS_YELLOW: begin ns_d = 3'b010; ew_d = 3'b001; end
      EW_GREEN:  begin ns_d = 3'b001; ew_d = 3'b100; end
      EW_YELLOW: begin ns_d = 3'b001; ew_d = 3'b010; end
      FLASH: begin
        ns_d = phase_d ? 3'b010 : 3'b000;
        ew_d = phase_d ? 3'b010 : 3'b000;
      end
      default:   begin ns_d = 3'b001; ew_d = 3'b001; end
    endcase
  end

endmodule
